pool_bram_1d: RTL

POOL_BRAM_1D -- requirements
Module: pool_bram_1d

---
 rtl/pool_1d_pkg.sv | 23 ++
 rtl/pool_bram_1d_dpath.sv | 49 ++++
 rtl/pool_bram_1d.sv | 109 ++++++++++
 3 files changed

// File: rtl/pool_1d_pkg.sv
// pool_1d_pkg: FSM states and signed max / ReLU helpers shared by the 1-D pooling block
package pool_1d_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam int MAX_DW = 64;

    // Operands arrive sign-extended from the sample width, which keeps their ordering unchanged.
    function automatic logic signed [MAX_DW-1:0] smax(
        input logic signed [MAX_DW-1:0] a,
        input logic signed [MAX_DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [MAX_DW-1:0] relu(
        input logic signed [MAX_DW-1:0] a,
        input logic en
    );
        return (en && a < 0) ? '0 : a;
    endfunction

endpackage

// File: rtl/pool_bram_1d_dpath.sv
// pool_bram_1d_dpath: per-channel running max, optional ReLU and registered pooled-RAM write port
//   clk, reset   : clock, asynchronous active-low reset
//   vld          : returning sample on rd_data is valid this cycle
//   first, last  : sample is the first / last tap of its window
//   idx          : window index carried with the sample
//   rd_data      : returned signed sample
//   wr_addr, wr_data, wr_en : registered pooled RAM write
module pool_bram_1d_dpath
    import pool_1d_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OUT_ADDR_WIDTH = 4,
    parameter int RELU_EN        = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vld,
    input  logic                      first,
    input  logic                      last,
    input  logic [OUT_ADDR_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic [OUT_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_en
);

    logic signed [DATA_WIDTH-1:0] sample, run_max, cur_max;

    assign sample  = rd_data;
    assign cur_max = first ? sample : DATA_WIDTH'(smax(MAX_DW'(sample), MAX_DW'(run_max)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_max <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= vld && last;
            if (vld)
                run_max <= cur_max;
            if (vld && last) begin
                wr_addr <= idx;
                wr_data <= DATA_WIDTH'(relu(MAX_DW'(cur_max), RELU_EN != 0));
            end
        end
    end

endmodule

// File: rtl/pool_bram_1d.sv
// pool_bram_1d: 1-D max pooling over IMG_D conv result RAMs into IMG_D pooled RAMs
//   clk, reset   : clock, asynchronous active-low reset
//   val_in       : conv result RAMs complete, start request (honoured only when rdy_in)
//   rdy_in       : idle and able to accept a start
//   in_rdaddr    : per-channel read address (same on every channel)
//   in_rddata    : per-channel read data, one cycle after its address
//   out_wraddr, out_wrdata, out_wren : per-channel pooled RAM write port
//   done         : one-cycle pulse after the last write of a pass
module pool_bram_1d
    import pool_1d_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 30,
    parameter int IMG_D      = 4,
    parameter int POOL_L     = 2,
    parameter int STRIDE_W   = 2,
    parameter int RELU_EN    = 1,
    localparam int OUT_W          = (IMG_W - POOL_L) / STRIDE_W + 1,
    localparam int IN_ADDR_WIDTH  = $clog2(IMG_W),
    localparam int OUT_ADDR_WIDTH = $clog2(OUT_W)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              val_in,
    output logic                              rdy_in,
    output logic [IN_ADDR_WIDTH*IMG_D-1:0]    in_rdaddr,
    input  logic [DATA_WIDTH*IMG_D-1:0]       in_rddata,
    output logic [OUT_ADDR_WIDTH*IMG_D-1:0]   out_wraddr,
    output logic [DATA_WIDTH*IMG_D-1:0]       out_wrdata,
    output logic [IMG_D-1:0]                  out_wren,
    output logic                              done
);

    localparam int K_W = (POOL_L > 1) ? $clog2(POOL_L) : 1;

    state_t                    state, state_nx;
    logic [OUT_ADDR_WIDTH-1:0] o, o1;
    logic [K_W-1:0]            k, k1;
    logic                      v1, drain_cnt, last_k, last_tap;
    logic [IN_ADDR_WIDTH-1:0]  rd_addr;

    assign last_k   = k == K_W'(POOL_L - 1);
    assign last_tap = last_k && (o == OUT_ADDR_WIDTH'(OUT_W - 1));
    // o and k sit at zero outside READ, so the address idles at 0.
    assign rd_addr  = IN_ADDR_WIDTH'(32'(o) * STRIDE_W + 32'(k));
    assign in_rdaddr = {IMG_D{rd_addr}};
    assign rdy_in   = state == IDLE;
    assign done     = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = val_in ? READ : IDLE;
            READ:    state_nx = last_tap ? DRAIN : READ;
            DRAIN:   state_nx = drain_cnt ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Window/tap counters plus a one-stage valid pipeline that lines o/k up with the RAM data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o         <= '0;
            k         <= '0;
            o1        <= '0;
            k1        <= '0;
            v1        <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            v1        <= state == READ;
            o1        <= o;
            k1        <= k;
            drain_cnt <= (state == DRAIN) && !drain_cnt;
            if (state == READ) begin
                k <= last_k ? '0 : k + 1'b1;
                if (last_k)
                    o <= last_tap ? '0 : o + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < IMG_D; c++) begin : g_ch
        pool_bram_1d_dpath #(
            .DATA_WIDTH(DATA_WIDTH),
            .OUT_ADDR_WIDTH(OUT_ADDR_WIDTH),
            .RELU_EN(RELU_EN)
        ) u_dpath (
            .clk(clk),
            .reset(reset),
            .vld(v1),
            .first(k1 == '0),
            .last(k1 == K_W'(POOL_L - 1)),
            .idx(o1),
            .rd_data(in_rddata[c*DATA_WIDTH +: DATA_WIDTH]),
            .wr_addr(out_wraddr[c*OUT_ADDR_WIDTH +: OUT_ADDR_WIDTH]),
            .wr_data(out_wrdata[c*DATA_WIDTH +: DATA_WIDTH]),
            .wr_en(out_wren[c])
        );
    end

endmodule
